stochastic_number_generator: RTL and testbench
==============================================

Name: stochastic_number_generator

Overview:
Binary-to-stochastic encoder. Converts an unsigned WIDTH-bit value into a unipolar bitstream of programmable length, where P(bit=1) = value/(2^WIDTH-1). It is the producer end of the bitstream interface: its outputs feed stochastic_multiplier operand inputs and other bitstream consumers. An internal maximal-length LFSR is compared against the latched value once per cycle.

Parameters:
WIDTH, 8, value and LFSR width; supported values are 8, 12 and 16.
LEN_W, 16, width of the stream-length field.
SEED, 'h01, default LFSR state after reset. Must be nonzero.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a stream; sampled only in IDLE
value  input  WIDTH  probability numerator; latched on an accepted start
length  input  LEN_W  number of bits to emit; latched on an accepted start
seed  input  WIDTH  LFSR seed
seed_load  input  1  loads seed into the LFSR; honoured only in IDLE
bitstream  output  1  stochastic bit, registered
bit_valid  output  1  bitstream is meaningful this cycle
busy  output  1  high from the accepted start until the done cycle, inclusive
done  output  1  one-cycle pulse at the end of the stream

Behaviour:
- Reset (rst=0, asynchronous):
  - bitstream, bit_valid, busy and done = 0.
  - state = IDLE, lfsr = SEED, count = 0, value_q = 0.
  - Deassertion takes effect at the next clk edge.
- Reset mid-stream aborts the stream. No done pulse is generated.
- LFSR:
  - Fibonacci, maximal length, tap masks from the package.
  - Cycles through 1..2^WIDTH-1 and never reaches 0.
  - Advances only in RUN, one step per emitted bit.
  - Persists across streams; it is not reseeded per start.
- Bit rule: bitstream = (lfsr <= value_q), unsigned comparison.
  - value_q = 0 gives all zeros.
  - value_q = 2^WIDTH-1 gives all ones.
  - Over any aligned full LFSR period, the count of ones equals value_q exactly.
- FSM:
  - IDLE:
    - start=1 with length≠0: latch value and length, count=0, busy=1, go to RUN.
    - start=1 with length=0: go to DONE; busy=1 for that single cycle.
    - seed_load=1: lfsr = (seed==0) ? SEED : seed. A zero seed is replaced to avoid lockup.
    - If start and seed_load are both asserted, seed_load is applied first. The new seed is the first state used by the stream.
  - RUN:
    - Each cycle: bit_valid=1, bitstream per the bit rule, lfsr advances, count increments.
    - When count reaches length_q-1 in the same cycle the final bit is emitted, go to DONE.
  - DONE: done=1, busy=1, bit_valid=0, then go to IDLE.
- Latency: start sampled at edge k → first bit_valid at edge k+1 → last bit at edge k+length → done at edge k+length+1 → busy falls at edge k+length+2.
  - A new start is accepted in the first IDLE cycle after that.
- Ignored inputs:
  - start in RUN or DONE is ignored. There is no queuing.
  - seed_load outside IDLE is ignored.
- Outside RUN, bitstream = 0 and bit_valid = 0.
- Maximum length is 2^LEN_W-1. The count register is LEN_W bits and does not wrap within a stream.

Decomposition:
- Shared package sc_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Function lfsr_taps(WIDTH) returning feedback masks: 8 → x^8+x^6+x^5+x^4+1; 12 → x^12+x^6+x^4+x^1+1; 16 → x^16+x^14+x^13+x^11+1.
  - The stochastic bit-rule comparison, so decoders and other generators share it.
- Sub-module sc_lfsr (WIDTH, SEED):
  - Inputs: clk, rst, advance, load, load_val.
  - Output: state.
  - Reused by every future generator or correlation-control block.

Test Plan:
- Reset with SEED=1, WIDTH=8; start with value=128, length=255 → 255 bit_valid cycles, exactly 128 ones, done at cycle 256 after start, busy low at cycle 257.
- value=0, length=255 → 0 ones. value=255, length=255 → 255 ones. value=1, length=255 → exactly 1 one.
- length=0 → no bit_valid; done high exactly one cycle, one cycle after start; busy high for that single cycle only.
- start pulsed every cycle during a length=10 stream → exactly 10 bits and one done. seed_load during RUN leaves the LFSR sequence unchanged versus the reference model.
- seed_load with seed=0 in IDLE → LFSR equals SEED. seed_load with seed=0x5A together with start, length=1 → emitted bit equals (0x5A <= value).
- rst pulsed low for 2 cycles mid-stream, 50 bits into length=200 → all outputs 0 immediately, no done. After release, a new start runs from lfsr=SEED and matches a fresh-reset stream bit-for-bit.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for stochastic-computing blocks: FSM states, LFSR feedback
// polynomials and the unipolar bit rule used by every generator and decoder.
package sc_pkg;

  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_state_e;

  // Fibonacci feedback masks; bit (e-1) is set for each polynomial term x^e.
  function automatic logic [MAX_W-1:0] lfsr_taps(input int width);
    case (width)
      8:       return 16'h00B8;  // x^8  + x^6  + x^5  + x^4 + 1
      12:      return 16'h0829;  // x^12 + x^6  + x^4  + x^1 + 1
      16:      return 16'hB400;  // x^16 + x^14 + x^13 + x^11 + 1
      default: return 16'h00B8;
    endcase
  endfunction

  // Unipolar encoding: a random draw at or below the value yields a one.
  function automatic logic sc_bit(input logic [MAX_W-1:0] rnd,
                                  input logic [MAX_W-1:0] val);
    return rnd <= val;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR with load and advance controls; a zero load
// value is replaced by SEED so the register can never lock up at zero.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  localparam logic [MAX_W-1:0] TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] state_q, state_d;
  logic             feedback;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    feedback = ^(state_q & TAPS);
    state_d  = state_q;
    if (load) begin
      state_d = (load_val == '0) ? SEED : load_val;
    end else if (advance) begin
      state_d = {state_q[WIDTH-2:0], feedback};
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/stochastic_number_generator.sv
// Binary-to-stochastic encoder: emits `length` registered bits whose ones
// density is value/(2^WIDTH-1), drawn from a persistent maximal-length LFSR.
module stochastic_number_generator
  import sc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               LEN_W = 16,
  parameter logic [WIDTH-1:0] SEED  = 'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic [LEN_W-1:0] length,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  output logic             bitstream,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  sc_state_e        state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             lfsr_adv, lfsr_load;
  logic [WIDTH-1:0] lfsr_state;
  logic             bit_now;
  logic             bitstream_q, bit_valid_q, busy_q, done_q;

  sc_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .advance  (lfsr_adv),
    .load     (lfsr_load),
    .load_val (seed),
    .state    (lfsr_state)
  );

  assign bit_now = sc_bit(MAX_W'(lfsr_state), MAX_W'(value_q));

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    length_d  = length_q;
    count_d   = count_q;
    lfsr_adv  = 1'b0;
    lfsr_load = 1'b0;
    case (state_q)
      IDLE: begin
        // A seed loaded alongside start is the first state the stream uses.
        lfsr_load = seed_load;
        if (start) begin
          if (length != '0) begin
            value_d  = value;
            length_d = length;
            count_d  = '0;
            state_d  = RUN;
          end else begin
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        lfsr_adv = 1'b1;
        if (count_q == length_q - LEN_W'(1)) begin
          state_d = DONE;
        end else begin
          count_d = count_q + LEN_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      value_q     <= '0;
      length_q    <= '0;
      count_q     <= '0;
      bitstream_q <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      length_q    <= length_d;
      count_q     <= count_d;
      // Outputs trail the state by one edge, so the bit drawn in RUN appears next cycle.
      bitstream_q <= (state_q == RUN) && bit_now;
      bit_valid_q <= (state_q == RUN);
      busy_q      <= (state_q != IDLE);
      done_q      <= (state_q == DONE);
    end
  end

  assign bitstream = bitstream_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_stochastic_number_generator.sv
// Self-checking bench for stochastic_number_generator (WIDTH=8, SEED=1): a
// sequence-level model predicts every emitted bit; directed streams pin timing.
module tb_stochastic_number_generator;

  localparam int         WIDTH = 8;
  localparam int         LEN_W = 16;
  localparam logic [7:0] SEED  = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic [7:0]  value = '0;
  logic [7:0]  seed = '0;
  logic [15:0] length = '0;
  logic        bitstream, bit_valid, busy, done;

  int checks = 0;
  int failures = 0;

  int model_lfsr;
  bit exp_q[$];
  bit got_bits[512];
  bit ref_bits[512];

  stochastic_number_generator #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W),
    .SEED  (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .length    (length),
    .seed      (seed),
    .seed_load (seed_load),
    .bitstream (bitstream),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Next state of x^8+x^6+x^5+x^4+1: shift left, feed back the XOR of terms 8,6,5,4.
  function automatic int lfsr_next(input int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return ((s << 1) | fb) & 255;
  endfunction

  // Every cycle: outputs are zero in reset, each valid bit matches the model, idle bits are zero.
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_outputs", {bitstream, bit_valid, busy, done}, 0);
      end else if (bit_valid) begin
        check("bit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stream_bit", bitstream, e);
        end
      end else begin
        check("idle_bitstream", bitstream, 0);
      end
    end
  end

  task automatic run_stream(input int v, input int len, input bit do_seed, input int sd,
                            input bit noise, input string tag, output int ones);
    int nb, ndone, done_c, busy_low, c;
    nb = 0; ndone = 0; done_c = -1; busy_low = -1; ones = 0; c = 0;
    start = 1'b1; value = 8'(v); length = 16'(len); seed_load = do_seed; seed = 8'(sd);
    @(posedge clk);
    if (do_seed) model_lfsr = (sd == 0) ? int'(SEED) : sd;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(model_lfsr <= v);
      model_lfsr = lfsr_next(model_lfsr);
    end
    #1;
    if (noise) begin
      seed_load = 1'b1; seed = 8'hC3;
    end else begin
      start = 1'b0; seed_load = 1'b0;
    end
    while (busy_low < 0 && c < len + 8) begin
      @(posedge clk);
      c++;
      #1;
      if (bit_valid) begin
        if (nb < 512) got_bits[nb] = bitstream;
        nb++;
        ones += int'(bitstream);
      end
      if (done) begin
        ndone++;
        done_c = c;
      end
      if (!busy) busy_low = c;
      if (noise && c == len) begin
        start = 1'b0; seed_load = 1'b0;
      end
    end
    start = 1'b0; seed_load = 1'b0;
    check($sformatf("%s_nbits", tag), nb, len);
    check($sformatf("%s_done_pulses", tag), ndone, 1);
    check($sformatf("%s_done_cycle", tag), done_c, len + 1);
    check($sformatf("%s_busy_low_cycle", tag), busy_low, len + 2);
  endtask

  task automatic seed_only(input int sd);
    seed_load = 1'b1; seed = 8'(sd);
    @(posedge clk);
    model_lfsr = (sd == 0) ? int'(SEED) : sd;
    #1;
    seed_load = 1'b0;
  endtask

  initial begin
    int s, n, ones, ndone, mism;

    // Pin the model against hand-derived steps and the full period.
    check("model_step_1", lfsr_next(1), 2);
    check("model_step_4", lfsr_next(4), 8);
    check("model_step_8", lfsr_next(8), 17);
    s = 1; n = 0;
    do begin
      s = lfsr_next(s);
      n++;
    end while (s != 1 && n < 300);
    check("model_period", n, 255);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {bitstream, bit_valid, busy, done}, 0);
    rst = 1'b1;
    model_lfsr = SEED;
    @(posedge clk);
    #1;

    // Full-period streams: ones count equals the value exactly.
    run_stream(128, 255, 0, 0, 0, "half", ones);
    check("half_ones", ones, 128);
    for (int i = 0; i < 255; i++) ref_bits[i] = got_bits[i];
    run_stream(0, 255, 0, 0, 0, "zero", ones);
    check("zero_ones", ones, 0);
    run_stream(255, 255, 0, 0, 0, "full", ones);
    check("full_ones", ones, 255);
    run_stream(1, 255, 0, 0, 0, "one", ones);
    check("one_ones", ones, 1);

    run_stream(100, 0, 0, 0, 0, "len0", ones);

    // start and seed_load held through RUN must be ignored.
    run_stream(200, 10, 0, 0, 1, "noise", ones);

    // Seed loaded together with start is the first state used.
    run_stream(8'h5A, 1, 1, 8'h5A, 0, "seed5a_eq", ones);
    check("seed5a_eq_bit", ones, 1);
    run_stream(8'h59, 1, 1, 8'h5A, 0, "seed5a_lt", ones);
    check("seed5a_lt_bit", ones, 0);

    // Zero seed falls back to SEED: lfsr 1 then 2 against value 1 gives 1,0.
    seed_only(0);
    run_stream(1, 2, 0, 0, 0, "seed0", ones);
    check("seed0_ones", ones, 1);
    check("seed0_first_bit", got_bits[0], 1);

    // Abort a 200-bit stream after 50 bits with a 2-cycle reset.
    start = 1'b1; value = 8'd128; length = 16'd200;
    @(posedge clk);
    for (int i = 0; i < 200; i++) begin
      exp_q.push_back(model_lfsr <= 128);
      model_lfsr = lfsr_next(model_lfsr);
    end
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("abort_outputs_zero", {bitstream, bit_valid, busy, done}, 0);
    ndone = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      ndone += int'(done);
    end
    rst = 1'b1;
    model_lfsr = SEED;
    repeat (3) begin
      @(posedge clk);
      #1;
      ndone += int'(done);
    end
    check("abort_no_done", ndone, 0);
    run_stream(128, 200, 0, 0, 0, "rerun", ones);
    mism = 0;
    for (int i = 0; i < 200; i++) if (got_bits[i] != ref_bits[i]) mism++;
    check("rerun_matches_fresh", mism, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
